// File: rtl/prio_enc_pkg.sv
// Shared widths and codes for the 4-to-2 priority encoder.
// N is fixed at 4 in this revision; YW follows from N and is not meant to be overridden.
package prio_enc_pkg;

  localparam int N  = 4;
  localparam int YW = $clog2(N);

  // Code reported alongside V=0; also the D[0]-only code, so Y is meaningless without V.
  localparam logic [YW-1:0] Y_NONE = 2'b00;

endpackage : prio_enc_pkg

// File: rtl/prio_enc_4x2_core.sv
// Combinational priority encode of D, highest index wins; zero latency.
// No flow control: outputs follow D continuously.
module prio_enc_4x2_core
  import prio_enc_pkg::*;
(
  input  logic [N-1:0]  D,
  output logic [YW-1:0] y_nxt,
  output logic          v_nxt
);

  always_comb begin
    y_nxt = Y_NONE;
    v_nxt = 1'b0;
    casez (D)
      4'b1???: begin y_nxt = 2'b11; v_nxt = 1'b1; end
      4'b01??: begin y_nxt = 2'b10; v_nxt = 1'b1; end
      4'b001?: begin y_nxt = 2'b01; v_nxt = 1'b1; end
      4'b0001: begin y_nxt = 2'b00; v_nxt = 1'b1; end
      default: begin y_nxt = Y_NONE; v_nxt = 1'b0; end
    endcase
  end

endmodule : prio_enc_4x2_core

// File: rtl/prio_enc_4x2.sv
// Registered 4-input priority encoder: Y/V reflect D one clk edge later.
// No handshake or back-pressure; a fresh result is registered every cycle.
module prio_enc_4x2
  import prio_enc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  D,
  output logic [YW-1:0] Y,
  output logic          V
);

  logic [YW-1:0] y_d, y_q;
  logic          v_d, v_q;

  prio_enc_4x2_core u_core (
    .D     (D),
    .y_nxt (y_d),
    .v_nxt (v_d)
  );

  // Outputs come straight from flops so mid-cycle D activity never reaches Y/V.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= Y_NONE;
      v_q <= 1'b0;
    end else begin
      y_q <= y_d;
      v_q <= v_d;
    end
  end

  assign Y = y_q;
  assign V = v_q;

endmodule : prio_enc_4x2

// File: tb/tb_prio_enc_4x2.sv
// Directed-vector bench for prio_enc_4x2 with a running encode-property assertion.
module tb_prio_enc_4x2;

  logic       clk;
  logic       rst_n;
  logic [3:0] D;
  logic [1:0] Y;
  logic       V;

  int checks   = 0;
  int failures = 0;

  // Hand-computed {V,Y} for each D value 0..15.
  logic [2:0] exp_tab [16];

  logic [3:0] d_prev;
  logic       prev_vld;

  prio_enc_4x2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D),
    .Y     (Y),
    .V     (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remember D at each edge so the registered outputs can be checked against it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vld <= 1'b0;
      d_prev   <= 4'b0000;
    end else begin
      prev_vld <= 1'b1;
      d_prev   <= D;
    end
  end

  always @(negedge clk) begin
    if (rst_n && prev_vld) begin
      assert ((V == |d_prev) &&
              (!V || (d_prev[Y] && ((d_prev >> Y) >> 1) == 4'b0000)))
        else $error("FAIL assert_encode d_prev=%b Y=%b V=%b", d_prev, Y, V);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_tab[0]  = 3'b000;
    exp_tab[1]  = 3'b100;
    exp_tab[2]  = 3'b101;
    exp_tab[3]  = 3'b101;
    for (int i = 4; i < 8; i++)  exp_tab[i] = 3'b110;
    for (int i = 8; i < 16; i++) exp_tab[i] = 3'b111;

    // 1: reset held with requests present, then release.
    rst_n = 1'b0;
    D     = 4'b1010;
    #1;
    chk("rst_immediate", {5'b0, V, Y}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_edges", {5'b0, V, Y}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_noedge", {5'b0, V, Y}, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_first_edge", {5'b0, V, Y}, 8'h07);

    // 2: full sweep, one value per cycle.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      D = 4'(i);
      @(posedge clk);
      #1;
      chk($sformatf("sweep_%0d", i), {5'b0, V, Y}, {5'b0, exp_tab[i]});
    end

    // 3: V alone separates D[0]-only from no request.
    @(negedge clk); D = 4'b0001;
    @(posedge clk); #1;
    chk("d0_only", {5'b0, V, Y}, 8'h04);
    @(negedge clk); D = 4'b0000;
    @(posedge clk); #1;
    chk("none", {5'b0, V, Y}, 8'h00);

    // 4: lower bits masked by higher ones.
    @(negedge clk); D = 4'b1111;
    @(posedge clk); #1;
    chk("mask_1111", {5'b0, V, Y}, 8'h07);
    @(negedge clk); D = 4'b0111;
    @(posedge clk); #1;
    chk("mask_0111", {5'b0, V, Y}, 8'h06);
    @(negedge clk); D = 4'b0011;
    @(posedge clk); #1;
    chk("mask_0011", {5'b0, V, Y}, 8'h05);

    // 5: asynchronous reset pulse between edges.
    @(negedge clk); D = 4'b0100;
    @(posedge clk); #1;
    chk("pre_pulse", {5'b0, V, Y}, 8'h06);
    #1 rst_n = 1'b0;
    #1;
    chk("pulse_async_clear", {5'b0, V, Y}, 8'h00);
    #1 rst_n = 1'b1;
    #2;
    chk("pulse_released_noedge", {5'b0, V, Y}, 8'h00);
    @(posedge clk); #1;
    chk("pulse_first_edge", {5'b0, V, Y}, 8'h06);

    // 6: D toggles within one cycle; only the value at the edge counts.
    @(negedge clk); D = 4'b0001;
    #1 D = 4'b1000;
    #1 D = 4'b0010;
    #1;
    chk("midcycle_hold", {5'b0, V, Y}, 8'h06);
    @(posedge clk); #1;
    chk("midcycle_edge", {5'b0, V, Y}, 8'h05);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prio_enc_4x2
